dot_accumulator: RTL and testbench

Downstream stage of the 4-element pipelined vector adder. Consumes its 34-bit partial sums one chunk at a time and accumulates `NUM_CHUNKS` consecutive chunks into one dot-product result, so a row·column product of length `4*NUM_CHUNKS` is built from repeated 4-wide adder passes. Completed results go into a 2-entry output buffer with a valid/ready handshake. The result collector can therefore stall without blocking accumulation of the next dot product.

---
 rtl/dot_accumulator.sv | 164 ++++++++++++++++
 tb/tb_dot_accumulator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dot_accumulator.sv
// Accumulates NUM_CHUNKS unsigned partial sums per dot product into a 2-entry result FIFO.
// Define DOT_ACC_SAT_EN to saturate the pushed result instead of wrapping it modulo 2^OUT_W.
module dot_accumulator #(
  parameter int NUM_CHUNKS = 4,
  parameter int IN_W       = 34,
  parameter int OUT_W      = 36
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_sum,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_sum,
  input  logic             out_ready,
  output logic             busy,
  output logic [7:0]       chunk_cnt
);

  localparam int SUM_W  = ((OUT_W > IN_W) ? OUT_W : IN_W) + 1;
  localparam int GROW_W = IN_W + $clog2(NUM_CHUNKS) + 1;
  localparam int ACC_W  = (SUM_W > GROW_W) ? SUM_W : GROW_W;
  localparam logic [7:0] LAST_CNT = 8'(NUM_CHUNKS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  in_ext_s, sum_s;
  logic [OUT_W-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
  logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              accept_s, final_s, push_s, pop_s;
  logic [OUT_W-1:0]  result_s;

  // The accumulator never overflows, so only the pushed value needs fitting to OUT_W.
  function automatic logic [OUT_W-1:0] fit_result(input logic [ACC_W-1:0] v);
`ifdef DOT_ACC_SAT_EN
    if (|v[ACC_W-1:OUT_W]) begin
      fit_result = {OUT_W{1'b1}};
    end else begin
      fit_result = v[OUT_W-1:0];
    end
`else
    fit_result = v[OUT_W-1:0];
`endif
  endfunction

  // Handshake and datapath terms; in_ready depends on registered state only.
  always_comb begin
    in_ready  = (cnt_q != LAST_CNT) || (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    accept_s  = in_valid && in_ready;
    final_s   = (state_q == ACCUM) && (cnt_q == LAST_CNT);
    push_s    = accept_s && final_s && !Clear;
    pop_s     = out_valid && out_ready;
    in_ext_s  = {{(ACC_W-IN_W){1'b0}}, in_sum};
    sum_s     = acc_q + in_ext_s;
    result_s  = fit_result(sum_s);
    busy      = (state_q == ACCUM);
    chunk_cnt = cnt_q;
    if (out_valid) begin
      out_sum = rd_ptr_q ? buf1_q : buf0_q;
    end else begin
      out_sum = {OUT_W{1'b0}};
    end
  end

  // Accumulation FSM next state; Clear overrides a coincident accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    if (Clear) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
      acc_d   = {ACC_W{1'b0}};
    end else if (accept_s) begin
      case (state_q)
        IDLE: begin
          acc_d   = in_ext_s;
          cnt_d   = 8'd1;
          state_d = ACCUM;
        end
        ACCUM: begin
          if (final_s) begin
            acc_d   = {ACC_W{1'b0}};
            cnt_d   = 8'd0;
            state_d = IDLE;
          end else begin
            acc_d   = sum_s;
            cnt_d   = cnt_q + 8'd1;
            state_d = ACCUM;
          end
        end
        default: begin
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = 8'd0;
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Result FIFO next state; simultaneous push and pop leave the count unchanged.
  always_comb begin
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      if (wr_ptr_q) begin
        buf1_d = result_s;
      end else begin
        buf0_d = result_s;
      end
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      acc_q    <= {ACC_W{1'b0}};
      buf0_q   <= {OUT_W{1'b0}};
      buf1_q   <= {OUT_W{1'b0}};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_dot_accumulator.sv
// Self-checking bench for dot_accumulator: directed scenarios plus random traffic vs a queue model.
module tb_dot_accumulator;

  localparam int N = 4;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Clear, in_valid, out_ready;
  logic [33:0] in_sum;
  logic        in_ready, out_valid, busy;
  logic [35:0] out_sum;
  logic [7:0]  chunk_cnt;

  logic        Clear35, in_valid35, out_ready35;
  logic [33:0] in_sum35;
  logic        in_ready35, out_valid35, busy35;
  logic [34:0] out_sum35;
  logic [7:0]  chunk_cnt35;

  int n_checks = 0;
  int n_fail   = 0;
  longint unsigned exp_q[$];
  longint unsigned chunks[$];

  dot_accumulator #(.NUM_CHUNKS(N), .IN_W(34), .OUT_W(36)) u_dut (
    .Clock(Clock), .Reset_n(Reset_n), .Clear(Clear), .in_valid(in_valid), .in_sum(in_sum),
    .in_ready(in_ready), .out_valid(out_valid), .out_sum(out_sum), .out_ready(out_ready),
    .busy(busy), .chunk_cnt(chunk_cnt)
  );

  dot_accumulator #(.NUM_CHUNKS(N), .IN_W(34), .OUT_W(35)) u_dut35 (
    .Clock(Clock), .Reset_n(Reset_n), .Clear(Clear35), .in_valid(in_valid35), .in_sum(in_sum35),
    .in_ready(in_ready35), .out_valid(out_valid35), .out_sum(out_sum35), .out_ready(out_ready35),
    .busy(busy35), .chunk_cnt(chunk_cnt35)
  );

  always #5 Clock = ~Clock;

  function automatic longint unsigned fit(longint unsigned v, int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
`ifdef DOT_ACC_SAT_EN
    return (v > mx) ? mx : v;
`else
    return v & mx;
`endif
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_ready();
    return !((chunks.size() == N - 1) && (exp_q.size() == 2));
  endfunction

  task automatic check_outputs();
    chk("in_ready",  {63'd0, in_ready},  {63'd0, model_ready()});
    chk("out_valid", {63'd0, out_valid}, {63'd0, (exp_q.size() != 0)});
    chk("out_sum",   {28'd0, out_sum},   (exp_q.size() != 0) ? exp_q[0] : 64'd0);
    chk("busy",      {63'd0, busy},      {63'd0, (chunks.size() != 0)});
    chk("chunk_cnt", {56'd0, chunk_cnt}, 64'(chunks.size()));
  endtask

  // One clock: drive, check against the model, advance the model across the edge.
  task automatic cycle(logic v, logic [33:0] s, logic r, logic c);
    logic acc, pop;
    longint unsigned total;
    in_valid = v; in_sum = s; out_ready = r; Clear = c;
    #1;
    check_outputs();
    acc = v && model_ready();
    pop = (exp_q.size() != 0) && r;
    @(posedge Clock);
    if (pop) void'(exp_q.pop_front());
    if (c) begin
      chunks.delete();
    end else if (acc) begin
      chunks.push_back(longint'(s));
      if (chunks.size() == N) begin
        total = 0;
        foreach (chunks[i]) total += chunks[i];
        exp_q.push_back(fit(total, 36));
        chunks.delete();
      end
    end
    #1;
  endtask

  initial begin
    logic [33:0] all1;
    logic [63:0] exp35;
    all1 = '1;
    Reset_n = 1'b0; Clear = 1'b0; in_valid = 1'b0; in_sum = 34'd0; out_ready = 1'b0;
    Clear35 = 1'b0; in_valid35 = 1'b0; in_sum35 = 34'd0; out_ready35 = 1'b1;

    // Reset state
    @(posedge Clock); #1;
    check_outputs();
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    @(posedge Clock); #1;

    // OUT_W=35 overflow: wrap or saturate
    for (int i = 0; i < 4; i++) begin
      in_valid35 = 1'b1; in_sum35 = all1;
      #1;
      chk("in_ready35", {63'd0, in_ready35}, 64'd1);
      @(posedge Clock); #1;
    end
    in_valid35 = 1'b0;
`ifdef DOT_ACC_SAT_EN
    exp35 = (64'd1 << 35) - 64'd1;
`else
    exp35 = (64'd1 << 35) - 64'd4;
`endif
    chk("out_valid35", {63'd0, out_valid35}, 64'd1);
    chk("out_sum35", {29'd0, out_sum35}, exp35);
    @(posedge Clock); #1;
    chk("out_valid35_pop", {63'd0, out_valid35}, 64'd0);

    // Basic dot product
    cycle(1'b1, 34'h30, 1'b1, 1'b0);
    cycle(1'b1, 34'h10, 1'b1, 1'b0);
    cycle(1'b1, 34'h20, 1'b1, 1'b0);
    cycle(1'b1, 34'h08, 1'b1, 1'b0);
    chk("dot1", {28'd0, out_sum}, 64'h68);
    cycle(1'b0, 34'd0, 1'b1, 1'b0);
    cycle(1'b0, 34'd0, 1'b1, 1'b0);

    // Stalled consumer: two buffered, twelfth chunk stalls until after a pop
    for (int i = 0; i < 11; i++) cycle(1'b1, 34'd1, 1'b0, 1'b0);
    cycle(1'b1, 34'd1, 1'b0, 1'b0);
    cycle(1'b1, 34'd1, 1'b0, 1'b0);
    cycle(1'b1, 34'd1, 1'b1, 1'b0);
    cycle(1'b1, 34'd1, 1'b0, 1'b0);
    chk("stall_res", {28'd0, out_sum}, 64'h4);
    for (int i = 0; i < 3; i++) cycle(1'b0, 34'd0, 1'b1, 1'b0);

    // Clear discards partial accumulation, and a coincident chunk
    cycle(1'b1, 34'h5, 1'b1, 1'b0);
    cycle(1'b1, 34'h7, 1'b1, 1'b0);
    cycle(1'b1, 34'h9, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 34'd1, 1'b0, 1'b0);
    chk("clear_res", {28'd0, out_sum}, 64'h4);
    cycle(1'b0, 34'd0, 1'b1, 1'b0);
    cycle(1'b0, 34'd0, 1'b1, 1'b0);

    // Push and pop in the same cycle with one entry buffered
    for (int i = 1; i <= 4; i++) cycle(1'b1, 34'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 34'd5, 1'b0, 1'b0);
    cycle(1'b1, 34'd5, 1'b1, 1'b0);
    chk("pp_valid", {63'd0, out_valid}, 64'd1);
    chk("pp_sum", {28'd0, out_sum}, 64'd20);
    cycle(1'b0, 34'd0, 1'b1, 1'b0);
    cycle(1'b0, 34'd0, 1'b0, 1'b0);

    // Async reset mid-accumulation with a result buffered
    for (int i = 0; i < 6; i++) cycle(1'b1, 34'd3, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    Reset_n = 1'b0;
    exp_q.delete(); chunks.delete();
    #1;
    check_outputs();
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    @(posedge Clock); #1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, {2'($urandom_range(0, 3)), 32'($urandom)},
            $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 34'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
